// File: rtl/pk_word_streamer.sv
// Streams a packed public key as 64-bit words over valid/ready, marking
// SHAKE256 rate-block boundaries and the final word for the downstream absorber.
module pk_word_streamer #(
   parameter int unsigned PK_BITS    = 15616,
   parameter int unsigned WORD_BITS  = 64,
   parameter int unsigned NUM_WORDS  = 244,
   parameter int unsigned RATE_WORDS = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [PK_BITS-1:0]   linear_pk,
   output logic                 busy,
   output logic                 done,
   output logic [WORD_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 out_block_last,
   output logic [7:0]           out_index
);

   localparam int unsigned IDX_W = 8;
   localparam int unsigned BLK_W = $clog2(RATE_WORDS);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [BLK_W-1:0] BLK_END  = BLK_W'(RATE_WORDS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]           state, state_nx;
   logic [PK_BITS-1:0]   sr, sr_nx;
   logic [IDX_W-1:0]     cnt, cnt_nx;
   logic [BLK_W-1:0]     blk, blk_nx;
   logic                 busy_nx, done_nx, valid_nx, last_nx, blast_nx;
   logic [WORD_BITS-1:0] data_nx;
   logic [IDX_W-1:0]     idx_nx;
   logic                 hs;

   assign hs = out_valid && out_ready;

   // Next-state and next-output logic; every output register is loaded from here.
   always_comb begin
      state_nx = state;
      sr_nx    = sr;
      cnt_nx   = cnt;
      blk_nx   = blk;
      busy_nx  = busy;
      done_nx  = 1'b0;
      valid_nx = out_valid;
      data_nx  = out_data;
      idx_nx   = out_index;
      last_nx  = out_last;
      blast_nx = out_block_last;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_STREAM;
               sr_nx    = linear_pk;
               cnt_nx   = '0;
               blk_nx   = '0;
               busy_nx  = 1'b1;
               valid_nx = 1'b1;
               data_nx  = linear_pk[WORD_BITS-1:0];
               idx_nx   = '0;
               last_nx  = (LAST_IDX == '0);
               blast_nx = (LAST_IDX == '0) || (BLK_END == '0);
            end
         end
         S_STREAM: begin
            if (hs) begin
               sr_nx = sr >> WORD_BITS;
               if (cnt == LAST_IDX) begin
                  // Final word accepted: counter stays terminal, outputs return to idle values.
                  state_nx = S_DONE;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
                  valid_nx = 1'b0;
                  data_nx  = '0;
                  idx_nx   = '0;
                  last_nx  = 1'b0;
                  blast_nx = 1'b0;
               end else begin
                  cnt_nx   = cnt + IDX_W'(1);
                  blk_nx   = (blk == BLK_END) ? '0 : blk + BLK_W'(1);
                  data_nx  = sr[2*WORD_BITS-1:WORD_BITS];
                  idx_nx   = cnt_nx;
                  last_nx  = (cnt_nx == LAST_IDX);
                  blast_nx = (blk_nx == BLK_END) || (cnt_nx == LAST_IDX);
               end
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         sr             <= '0;
         cnt            <= '0;
         blk            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_index      <= '0;
         out_last       <= 1'b0;
         out_block_last <= 1'b0;
      end else begin
         state          <= state_nx;
         sr             <= sr_nx;
         cnt            <= cnt_nx;
         blk            <= blk_nx;
         busy           <= busy_nx;
         done           <= done_nx;
         out_valid      <= valid_nx;
         out_data       <= data_nx;
         out_index      <= idx_nx;
         out_last       <= last_nx;
         out_block_last <= blast_nx;
      end
   end

endmodule

// File: tb/tb_pk_word_streamer.sv
// Bench for pk_word_streamer: transaction-level model of the word stream
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pk_word_streamer;

   localparam int unsigned PK_BITS = 15616;
   localparam int unsigned NW      = 244;
   localparam int unsigned NBYTES  = 1952;

   logic               clk = 1'b0;
   logic               rst, start, out_ready;
   logic [PK_BITS-1:0] linear_pk;
   logic               busy, done, out_valid, out_last, out_block_last;
   logic [63:0]        out_data;
   logic [7:0]         out_index;

   pk_word_streamer dut (
      .clk(clk), .rst(rst), .start(start), .linear_pk(linear_pk),
      .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .out_block_last(out_block_last),
      .out_index(out_index)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Model: a stream is a sequence of 244 slices of the key captured at start.
   bit                 m_stream = 1'b0;
   bit                 m_done   = 1'b0;
   int                 m_idx    = 0;
   logic [PK_BITS-1:0] m_pk     = '0;
   int                 cyc      = 0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_stream = 1'b0; m_done = 1'b0; m_idx = 0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_stream) begin
         if (out_ready) begin
            if (m_idx == NW - 1) begin m_stream = 1'b0; m_done = 1'b1; end
            else m_idx++;
         end
      end else if (start) begin
         m_stream = 1'b1; m_idx = 0; m_pk = linear_pk;
      end
   end

   logic [63:0] q_data[$];
   int          q_cyc[$];
   int          done_cyc[$];
   int          bl_cnt = 0, last_cnt = 0, done_cnt = 0, stall_cnt = 0;
   bit          p_stall = 1'b0;
   logic [63:0] p_data;
   logic [7:0]  p_idx;
   logic        p_last, p_bl;
   logic [63:0] ew;
   logic        ebl;

   // Per-cycle compare against the model, stall stability, transaction log.
   always @(negedge clk) begin
      ew  = m_stream ? m_pk[64*m_idx +: 64] : 64'd0;
      ebl = m_stream && (((m_idx % 17) == 16) || (m_idx == NW - 1));
      chk("valid", 64'(out_valid), 64'(m_stream));
      chk("busy", 64'(busy), 64'(m_stream));
      chk("done", 64'(done), 64'(m_done));
      chk("data", out_data, ew);
      chk("index", 64'(out_index), m_stream ? 64'(m_idx) : 64'd0);
      chk("last", 64'(out_last), 64'(m_stream && (m_idx == NW - 1)));
      chk("block_last", 64'(out_block_last), 64'(ebl));
      if (p_stall) begin
         chk("stall_data", out_data, p_data);
         chk("stall_index", 64'(out_index), 64'(p_idx));
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_flags", {62'd0, out_last, out_block_last}, {62'd0, p_last, p_bl});
      end
      p_stall = out_valid && !out_ready && !rst;
      if (p_stall) stall_cnt++;
      p_data = out_data; p_idx = out_index; p_last = out_last; p_bl = out_block_last;
      if (out_valid && out_ready) begin
         q_data.push_back(out_data);
         q_cyc.push_back(cyc);
         if (out_block_last) bl_cnt++;
         if (out_last) last_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_pk(input int mul, input int add);
      for (int k = 0; k < NBYTES; k++) linear_pk[8*k +: 8] = 8'((k * mul + add) % 256);
   endtask

   task automatic wait_done(input int base, input int n, input int budget,
                            input bit rnd, input string name);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (rnd) out_ready = ($urandom_range(0, 9) < 3);
         if (done_cnt >= base + n) break;
      end
      out_ready = 1'b1;
      chk(name, 64'(done_cnt), 64'(base + n));
   endtask

   task automatic wait_index(input int idx, input string name);
      int seen = 0;
      for (int i = 0; i < 400; i++) begin
         if (out_valid && (out_index == 8'(idx))) begin seen = 1; break; end
         tick();
      end
      chk(name, 64'(seen), 64'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   logic [63:0] ref_q[$];
   int          d0, n0, mism;

   initial begin
      // Reset with start high: start must be ignored.
      rst = 1'b1; start = 1'b1; out_ready = 1'b1; fill_pk(1, 0);
      repeat (3) tick();
      start = 1'b0;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_index", 64'(out_index), 64'd0);
      rst = 1'b0;
      repeat (2) tick();
      chk("idle_valid", 64'(out_valid), 64'd0);

      // No backpressure.
      q_data.delete(); q_cyc.delete(); bl_cnt = 0; last_cnt = 0; d0 = done_cnt;
      pulse_start();
      chk("t1_word0_live", out_data, 64'h0706050403020100);
      wait_done(d0, 1, 400, 1'b0, "t1_done_timeout");
      chk("t1_count", 64'(q_data.size()), 64'(NW));
      if (q_data.size() == NW) begin
         chk("t1_word0", q_data[0], 64'h0706050403020100);
         chk("t1_word243", q_data[NW-1], 64'h9F9E9D9C9B9A9998);
         chk("t1_consecutive", 64'(q_cyc[NW-1] - q_cyc[0]), 64'd243);
         chk("t1_done_lag", 64'(done_cyc[done_cyc.size()-1] - q_cyc[NW-1]), 64'd1);
      end
      chk("t1_block_last_cnt", 64'(bl_cnt), 64'd15);
      chk("t1_last_cnt", 64'(last_cnt), 64'd1);
      ref_q = q_data;

      // Random backpressure, 30% ready.
      repeat (3) tick();
      q_data.delete(); d0 = done_cnt; stall_cnt = 0;
      pulse_start();
      wait_done(d0, 1, 4000, 1'b1, "t3_done_timeout");
      chk("t3_count", 64'(q_data.size()), 64'(NW));
      mism = 0;
      for (int i = 0; i < NW; i++)
         if (i >= q_data.size() || i >= ref_q.size() || q_data[i] !== ref_q[i]) mism++;
      chk("t3_data_vs_ref", 64'(mism), 64'd0);
      chk("t3_stalls_seen", 64'(stall_cnt > 0), 64'd1);

      // Start while busy, with a different key.
      repeat (3) tick();
      q_data.delete(); d0 = done_cnt;
      pulse_start();
      wait_index(100, "t4_reach_100");
      fill_pk(7, 3);
      pulse_start();
      wait_done(d0, 1, 400, 1'b0, "t4_done_timeout");
      repeat (5) tick();
      chk("t4_done_once", 64'(done_cnt), 64'(d0 + 1));
      mism = 0;
      for (int i = 0; i < NW; i++)
         if (i >= q_data.size() || q_data[i] !== ref_q[i]) mism++;
      chk("t4_data_vs_ref", 64'(mism), 64'd0);
      fill_pk(1, 0);

      // Reset mid-stream.
      q_data.delete(); d0 = done_cnt;
      pulse_start();
      wait_index(50, "t5_reach_50");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_valid", 64'(out_valid), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      n0 = q_data.size();
      repeat (20) tick();
      chk("t5_no_words", 64'(q_data.size()), 64'(n0));
      chk("t5_no_done", 64'(done_cnt), 64'(d0));
      pulse_start();
      chk("t5_restart_word0", out_data, 64'h0706050403020100);
      chk("t5_restart_index", 64'(out_index), 64'd0);
      wait_done(d0, 1, 400, 1'b0, "t5_done_timeout");
      chk("t5_restart_count", 64'(q_data.size() - n0), 64'(NW));

      // Back-to-back with start held high.
      repeat (3) tick();
      q_data.delete(); d0 = done_cnt;
      start = 1'b1;
      wait_done(d0, 2, 1000, 1'b0, "t6_done_timeout");
      start = 1'b0;
      repeat (5) tick();
      chk("t6_done_cnt", 64'(done_cnt), 64'(d0 + 2));
      chk("t6_count", 64'(q_data.size()), 64'(2 * NW));
      if (done_cyc.size() >= 2)
         chk("t6_done_gap", 64'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 64'd246);
      if (q_data.size() == 2 * NW)
         chk("t6_second_word0", q_data[NW], 64'h0706050403020100);

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
